vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters SHALL be: ROWS, default 30, text rows; COLS, default 100, text columns; DEPTH, default 4, write FIFO entries; BLANK, default 8'h20, fill byte.
REQ-002 clk  in  1  pixel clock; the single clock domain.
REQ-003 reset_low  in  1  asynchronous, active-low reset.
REQ-004 disp_valid  in  1  display read request, one per character cell.
REQ-005 disp_row  in  5  physical row of the display read.
REQ-006 disp_col  in  7  column of the display read.
REQ-007 disp_byte  out  8  display read data, valid the cycle after disp_valid.
REQ-008 wr_valid  in  1  terminal write request.
REQ-009 wr_ready  out  1  terminal write accept; a write transfers when wr_valid and wr_ready are both high.
REQ-010 wr_row  in  5  logical (screen-relative) row of the write.
REQ-011 wr_col  in  7  column of the write.
REQ-012 wr_byte  in  8  character to write.
REQ-013 clear_start  in  1  one-cycle pulse; blank the whole screen.
REQ-014 scroll_up  in  1  one-cycle pulse; scroll the screen up by one row.
REQ-015 busy  out  1  a command is pending or executing.
REQ-016 top_row  out  5  physical row shown at screen top; drives the text-mode top_row input.
REQ-017 mem_ce  out  1  VRAM enable.
REQ-018 mem_we  out  1  VRAM write enable.
REQ-019 mem_addr  out  12  VRAM address.
REQ-020 mem_wdata  out  8  VRAM write data.
REQ-021 mem_rdata  in  8  VRAM read data; the VRAM is synchronous with 1-cycle read latency.

Function
REQ-022 Addresses SHALL be computed as phys_row*COLS+col, 12 bits, range 0..2999.
REQ-023 Display access SHALL have absolute priority: when disp_valid=1, the mem_* outputs SHALL be driven combinationally that cycle with ce=1, we=0, addr from disp_row/disp_col.
REQ-024 disp_byte SHALL equal mem_rdata (passthrough), so read latency is exactly 1 cycle.
REQ-025 Accepted writes SHALL enter a DEPTH-entry FIFO holding {addr, byte}.
REQ-026 The address SHALL be translated at acceptance using phys_row = (top_row+wr_row) mod ROWS, computed by compare-and-subtract, not by divide.
REQ-027 wr_ready SHALL equal (FIFO not full) AND (state==IDLE) AND NOT clear_start AND NOT scroll_up.
REQ-028 The FIFO SHALL pop one entry per cycle, issuing ce=1, we=1, only on cycles with disp_valid=0; FIFO order SHALL be preserved.
REQ-029 The state machine SHALL have the states IDLE, DRAIN, CLEAR and SCROLL.
REQ-030 IDLE transition: clear_start -> DRAIN with cmd=CLEAR; otherwise scroll_up -> DRAIN with cmd=SCROLL. When both arrive in the same cycle, clear SHALL win and the scroll SHALL be dropped.
REQ-031 DRAIN SHALL accept no new writes and SHALL go to the latched cmd state once the FIFO is empty, so writes accepted before a command land first.
REQ-032 CLEAR SHALL use a 12-bit counter 0..2999, writing BLANK on each cycle with disp_valid=0 (stalling otherwise); after address 2999 it SHALL set top_row to 0 and return to IDLE.
REQ-033 SCROLL SHALL write BLANK to columns 0..COLS-1 of physical row top_row (the outgoing top row, which becomes the new bottom row), with the same stall rule.
REQ-034 After SCROLL's column 99 write, top_row SHALL become (top_row==ROWS-1) ? 0 : top_row+1, and the state SHALL return to IDLE.
REQ-035 busy SHALL be high from the cycle after command acceptance until the cycle after the final command write; clear_start and scroll_up SHALL be ignored while busy=1.
REQ-036 With no access pending, mem_ce=0, mem_we=0, and mem_addr/mem_wdata are don't-care.

Reset
REQ-037 While reset_low=0 the block SHALL have: state IDLE, FIFO empty, counters 0, top_row=0, busy=0, cmd cleared.
REQ-038 VRAM contents SHALL NOT be cleared by reset.
REQ-039 wr_ready SHALL read 1 as soon as reset_low rises, with no synchronous drain cycles.
REQ-040 Reset asserted mid-CLEAR or mid-SCROLL SHALL abort the command immediately; top_row SHALL remain 0.

Verification
REQ-041 Display read: disp_valid=1, row 2, col 5 -> mem_addr=205 with ce=1, we=0 that cycle; disp_byte equals the RAM content on the next cycle.
REQ-042 Write contention: 4 writes with disp_valid held high -> FIFO full, wr_ready=0, no mem_we; drop disp_valid -> 4 writes on 4 consecutive cycles in order.
REQ-043 Translation: top_row=29, write at row 1, col 0 -> mem_addr=0; top_row=3, row 28 -> phys row 1, mem_addr=100.
REQ-044 Scroll: top_row=29, scroll_up -> 100 BLANK writes to addr 2900..2999, then top_row=0, busy=0.
REQ-045 Clear with display interleaved: clear_start with disp_valid toggling every cycle -> 3000 BLANK writes, none on disp_valid cycles; no display read dropped; final top_row=0.
REQ-046 Simultaneous commands and reset: clear_start and scroll_up in the same cycle -> only CLEAR executes; reset_low pulsed low mid-CLEAR -> IDLE, busy=0, wr_ready=1.

Source files
------------

// File: rtl/vram_arbiter.sv
// Text-mode VRAM arbiter: display reads take absolute priority, terminal writes
// are queued in a small FIFO, and clear/scroll commands sweep BLANK into VRAM.
module vram_arbiter #(
  parameter int unsigned ROWS  = 30,
  parameter int unsigned COLS  = 100,
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        reset_low,
  input  logic        disp_valid,
  input  logic [4:0]  disp_row,
  input  logic [6:0]  disp_col,
  output logic [7:0]  disp_byte,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_row,
  input  logic [6:0]  wr_col,
  input  logic [7:0]  wr_byte,
  input  logic        clear_start,
  input  logic        scroll_up,
  output logic        busy,
  output logic [4:0]  top_row,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ROW_W     = 5;
  localparam int unsigned COL_W     = 7;
  localparam int unsigned SUM_W     = ROW_W + 1;
  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned LAST_CELL = ROWS * COLS - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR, ST_SCROLL} state_e;
  typedef enum logic [1:0] {CMD_NONE, CMD_CLEAR, CMD_SCROLL} cmd_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  state_e            state_q, state_d;
  cmd_e              cmd_q, cmd_d;
  wr_entry_t         fifo_q [DEPTH];
  wr_entry_t         fifo_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0]  top_row_q, top_row_d;

  logic [SUM_W-1:0]  row_sum;
  logic [ROW_W-1:0]  phys_row;
  logic              push, pop;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_NONE;
      fifo_q    <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cnt_q     <= '0;
      top_row_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      top_row_q <= top_row_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    top_row_d = top_row_q;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pop       = 1'b0;

    wr_ready = (count_q != CNT_W'(DEPTH)) && (state_q == ST_IDLE) && !clear_start && !scroll_up;
    push     = wr_valid && wr_ready;

    // Screen-relative row to physical row, wrapping without a divider
    row_sum = SUM_W'(top_row_q) + SUM_W'(wr_row);
    if (row_sum >= SUM_W'(ROWS)) row_sum = row_sum - SUM_W'(ROWS);
    phys_row = row_sum[ROW_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_DRAIN;
          cmd_d   = CMD_CLEAR;
        end else if (scroll_up) begin
          state_d = ST_DRAIN;
          cmd_d   = CMD_SCROLL;
        end
      end
      ST_DRAIN: begin
        if (count_q == '0) state_d = (cmd_q == CMD_CLEAR) ? ST_CLEAR : ST_SCROLL;
      end
      ST_CLEAR: begin
        if (!disp_valid) begin
          mem_ce    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = cnt_q;
          mem_wdata = BLANK;
          if (cnt_q == ADDR_W'(LAST_CELL)) begin
            cnt_d     = '0;
            top_row_d = '0;
            cmd_d     = CMD_NONE;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      ST_SCROLL: begin
        // The outgoing top row is blanked and becomes the new bottom row
        if (!disp_valid) begin
          mem_ce    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = cell_addr(top_row_q, COL_W'(cnt_q));
          mem_wdata = BLANK;
          if (cnt_q == ADDR_W'(COLS - 1)) begin
            cnt_d     = '0;
            top_row_d = (top_row_q == ROW_W'(ROWS - 1)) ? '0 : top_row_q + ROW_W'(1);
            cmd_d     = CMD_NONE;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (disp_valid) begin
      mem_ce   = 1'b1;
      mem_we   = 1'b0;
      mem_addr = cell_addr(disp_row, disp_col);
    end else if ((count_q != '0) && ((state_q == ST_IDLE) || (state_q == ST_DRAIN))) begin
      pop       = 1'b1;
      mem_ce    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = fifo_q[rd_ptr_q].addr;
      mem_wdata = fifo_q[rd_ptr_q].data;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: cell_addr(phys_row, wr_col), data: wr_byte};
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign disp_byte = mem_rdata;
  assign busy      = (state_q != ST_IDLE);
  assign top_row   = top_row_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1-cycle synchronous VRAM model and
// a log of every VRAM write for order/content checks.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_low;
  logic        disp_valid;
  logic [4:0]  disp_row;
  logic [6:0]  disp_col;
  logic [7:0]  disp_byte;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_row;
  logic [6:0]  wr_col;
  logic [7:0]  wr_byte;
  logic        clear_start;
  logic        scroll_up;
  logic        busy;
  logic [4:0]  top_row;
  logic        mem_ce;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0]  vram [0:4095];
  logic [19:0] wlog [$];
  int          we_on_disp = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .reset_low(reset_low),
    .disp_valid(disp_valid), .disp_row(disp_row), .disp_col(disp_col), .disp_byte(disp_byte),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col), .wr_byte(wr_byte),
    .clear_start(clear_start), .scroll_up(scroll_up), .busy(busy), .top_row(top_row),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous VRAM, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      mem_rdata <= vram[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (reset_low && mem_ce && mem_we) begin
      wlog.push_back({mem_addr, mem_wdata});
      if (disp_valid) we_on_disp++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 10000) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_scroll(input logic [4:0] exp_top);
    scroll_up = 1'b1;
    tick();
    scroll_up = 1'b0;
    wait_idle("scroll");
    check("scroll_top", 32'(top_row), 32'(exp_top));
  endtask

  task automatic single_write(input logic [4:0] row, input logic [6:0] col,
                              input logic [7:0] data, input int exp_addr, input string tag);
    wr_valid = 1'b1; wr_row = row; wr_col = col; wr_byte = data;
    tick();
    wr_valid = 1'b0;
    #1;
    check({tag, "_we"}, 32'(mem_we), 32'd1);
    check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    check({tag, "_data"}, 32'(mem_wdata), 32'(data));
    tick();
  endtask

  initial begin
    int errs;
    int rd_err;
    int reads;
    int n;
    reset_low = 1'b0; disp_valid = 1'b0; disp_row = '0; disp_col = '0;
    wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_byte = '0;
    clear_start = 1'b0; scroll_up = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_top", 32'(top_row), 32'd0);
    check("rst_ce", 32'(mem_ce), 32'd0);
    reset_low = 1'b1;
    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd1);

    // Write a known byte, then read it back through the display port
    single_write(5'd2, 7'd5, 8'hA5, 205, "wr205");
    disp_valid = 1'b1; disp_row = 5'd2; disp_col = 7'd5;
    #1;
    check("disp_addr", 32'(mem_addr), 32'd205);
    check("disp_ce", 32'(mem_ce), 32'd1);
    check("disp_we", 32'(mem_we), 32'd0);
    tick();
    check("disp_byte", 32'(disp_byte), 32'hA5);

    // Fill the FIFO while the display owns the port
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_row = 5'd10; wr_col = 7'(1 + i); wr_byte = 8'(8'h41 + i);
      #1;
      check("fill_ready", 32'(wr_ready), 32'd1);
      tick();
    end
    wr_col = 7'd9;
    #1;
    check("full_ready", 32'(wr_ready), 32'd0);
    check("full_no_we", 32'(wlog.size()), 32'd0);
    wr_valid = 1'b0; disp_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_we", 32'(mem_we), 32'd1);
      check("drain_addr", 32'(mem_addr), 32'(1001 + i));
      check("drain_data", 32'(mem_wdata), 32'(8'h41 + i));
      tick();
    end
    check("drain_idle_ce", 32'(mem_ce), 32'd0);
    check("drain_ready", 32'(wr_ready), 32'd1);
    check("vram_1004", 32'(vram[1004]), 32'h44);

    // Row translation with top_row=3: row 28 -> phys 1
    for (int t = 1; t <= 3; t++) do_scroll(5'(t));
    single_write(5'd28, 7'd0, 8'h5A, 100, "xlate3");
    for (int t = 4; t <= 29; t++) do_scroll(5'(t));
    single_write(5'd1, 7'd0, 8'h66, 0, "xlate29");

    // Scroll from top_row=29 blanks row 29 and wraps top_row to 0
    wlog.delete(); we_on_disp = 0;
    do_scroll(5'd0);
    check("scroll_count", 32'(wlog.size()), 32'd100);
    errs = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i] !== {12'(2900 + i), 8'h20}) errs++;
    check("scroll_seq", 32'(errs), 32'd0);

    // Clear with display reads on alternate cycles and an ignored scroll
    do_scroll(5'd1);
    wlog.delete(); we_on_disp = 0; rd_err = 0; reads = 0; n = 0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    while (busy === 1'b1 && n < 20000) begin
      disp_valid = n[0];
      disp_row   = 5'(n % 30);
      disp_col   = 7'(n % 100);
      scroll_up  = (n == 50);
      #1;
      if (disp_valid) begin
        reads++;
        if (!(mem_ce === 1'b1 && mem_we === 1'b0 && mem_addr === 12'((n % 30) * 100 + (n % 100))))
          rd_err++;
      end
      tick();
      n++;
    end
    disp_valid = 1'b0; scroll_up = 1'b0;
    check("clear_idle", 32'(busy), 32'd0);
    check("clear_rd_err", 32'(rd_err), 32'd0);
    check("clear_reads", 32'(reads >= 3000), 32'd1);
    check("clear_count", 32'(wlog.size()), 32'd3000);
    check("clear_we_on_disp", 32'(we_on_disp), 32'd0);
    errs = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i] !== {12'(i), 8'h20}) errs++;
    check("clear_seq", 32'(errs), 32'd0);
    check("clear_top", 32'(top_row), 32'd0);
    tick(); tick();
    check("clear_no_scroll", 32'(busy), 32'd0);
    check("vram_1002_blank", 32'(vram[1002]), 32'h20);

    // Simultaneous clear and scroll: clear wins
    do_scroll(5'd1);
    wlog.delete();
    clear_start = 1'b1; scroll_up = 1'b1;
    tick();
    clear_start = 1'b0; scroll_up = 1'b0;
    wait_idle("both");
    check("both_top", 32'(top_row), 32'd0);
    check("both_count", 32'(wlog.size()), 32'd3000);
    tick(); tick();
    check("both_after", 32'(busy), 32'd0);

    // Reset in the middle of a clear
    do_scroll(5'd1);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (500) tick();
    check("mid_busy", 32'(busy), 32'd1);
    reset_low = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_top", 32'(top_row), 32'd0);
    check("abort_ce", 32'(mem_ce), 32'd0);
    tick();
    reset_low = 1'b1;
    #1;
    check("abort_ready", 32'(wr_ready), 32'd1);
    tick(); tick();
    check("abort_stays_idle", 32'(busy), 32'd0);
    check("abort_no_write", 32'(mem_ce), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
